// File: rtl/writeback_unit_if.sv
// Retire-side bus of writeback_unit: instruction handshake, load return,
// register_bank write port and operand-read forwarding/hazard signals.
interface writeback_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
);
   logic              IN_VALID;
   logic              IN_READY;
   logic [ADDR_W-1:0] DEST;
   logic              W_EN;
   logic [1:0]        SRC_SEL;
   logic [DATA_W-1:0] ALU_RES;
   logic [DATA_W-1:0] PC;
   logic [DATA_W-1:0] MEM_DATA;
   logic              MEM_VALID;
   logic [ADDR_W-1:0] RA;
   logic [ADDR_W-1:0] RB;
   logic [ADDR_W-1:0] WC;
   logic [DATA_W-1:0] WPC;
   logic              W_RB;
   logic              FWD_A;
   logic              FWD_B;
   logic [DATA_W-1:0] FWD_DATA;
   logic              HAZ;
   logic              ERR;

   modport master (
      output IN_VALID, DEST, W_EN, SRC_SEL, ALU_RES, PC, MEM_DATA, MEM_VALID, RA, RB,
      input  IN_READY, WC, WPC, W_RB, FWD_A, FWD_B, FWD_DATA, HAZ, ERR
   );

   modport slave (
      input  IN_VALID, DEST, W_EN, SRC_SEL, ALU_RES, PC, MEM_DATA, MEM_VALID, RA, RB,
      output IN_READY, WC, WPC, W_RB, FWD_A, FWD_B, FWD_DATA, HAZ, ERR
   );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: selects ALU / load / link result and commits it to
// register_bank as a single one-cycle write pulse, with forwarding and load hazard.
module writeback_unit #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned LINK_OFFSET = 1
) (
   input logic              CLK,
   input logic              RST,
   writeback_unit_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_dest;
   logic              r_wen;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_wc;
   logic [DATA_W-1:0] r_wpc;
   logic              r_wrb;
   logic              r_err;

   logic              w_accept;
   logic              w_expire;
   logic              w_err_evt;
   logic [ADDR_W-1:0] w_dest;
   logic              w_wen;
   logic [DATA_W-1:0] w_value;
   logic [DATA_W-1:0] w_link;
   logic              w_in_ready;
   logic              w_fwd_a, w_fwd_b, w_haz;
   logic [DATA_W-1:0] w_fwd_data;

   assign w_accept  = (r_state == IDLE) && bus.IN_VALID;
   assign w_expire  = (r_state == WAIT_MEM) && !bus.MEM_VALID
                      && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
   assign w_err_evt = (w_accept && (bus.SRC_SEL == 2'b11)) || w_expire;
   assign w_link    = bus.PC + DATA_W'(LINK_OFFSET);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               case (bus.SRC_SEL)
                  2'b00, 2'b10: w_next = COMMIT;
                  2'b01:        w_next = WAIT_MEM;
                  default:      w_next = IDLE;
               endcase
            end
         end
         WAIT_MEM: begin
            if (bus.MEM_VALID)  w_next = COMMIT;
            else if (w_expire)  w_next = IDLE;
         end
         COMMIT:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      w_in_ready = (r_state == IDLE);
      w_fwd_a    = (r_state == COMMIT) && r_wen && (bus.RA == r_dest);
      w_fwd_b    = (r_state == COMMIT) && r_wen && (bus.RB == r_dest);
      w_fwd_data = (r_state == COMMIT) ? r_wpc : '0;
      w_haz      = (r_state == WAIT_MEM) && r_wen
                   && ((bus.RA == r_dest) || (bus.RB == r_dest));
   end

   // Commit fields come straight from the bus on the ALU/LINK path, from the captured copy on a load
   always_comb begin
      w_dest  = (r_state == IDLE) ? bus.DEST : r_dest;
      w_wen   = (r_state == IDLE) ? bus.W_EN : r_wen;
      w_value = bus.MEM_DATA;
      if (r_state == IDLE) w_value = (bus.SRC_SEL == 2'b10) ? w_link : bus.ALU_RES;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_dest <= '0;
         r_wen  <= 1'b0;
         r_cnt  <= '0;
         r_wc   <= '0;
         r_wpc  <= '0;
         r_wrb  <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_err <= w_err_evt;
         r_wrb <= 1'b0;
         if (w_accept) begin
            r_dest <= bus.DEST;
            r_wen  <= bus.W_EN;
            r_cnt  <= '0;
         end else if (r_state == WAIT_MEM) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_next == COMMIT) begin
            r_wc  <= w_dest;
            r_wpc <= w_value;
            r_wrb <= w_wen;
         end
      end
   end

   assign bus.IN_READY = w_in_ready;
   assign bus.WC       = r_wc;
   assign bus.WPC      = r_wpc;
   assign bus.W_RB     = r_wrb;
   assign bus.FWD_A    = w_fwd_a;
   assign bus.FWD_B    = w_fwd_b;
   assign bus.FWD_DATA = w_fwd_data;
   assign bus.HAZ      = w_haz;
   assign bus.ERR      = r_err;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit with a behavioural register_bank.
module tb_writeback_unit;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   logic [31:0] regs [16];
   logic [31:0] vals [16];
   logic        prev_wrb = 1'b0;

   writeback_unit_if #(.DATA_W(32), .ADDR_W(4)) bus ();

   writeback_unit #(
      .DATA_W(32), .ADDR_W(4), .MEM_TIMEOUT(15), .LINK_OFFSET(1)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [3:0] d, input logic we, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc);
      bus.IN_VALID = 1'b1;
      bus.DEST     = d;
      bus.W_EN     = we;
      bus.SRC_SEL  = sel;
      bus.ALU_RES  = alu;
      bus.PC       = pc;
   endtask

   // register_bank model
   always @(posedge CLK) if (bus.W_RB) regs[bus.WC] <= bus.WPC;

   always @(negedge CLK) begin
      if (bus.W_RB) check("wrb_gap", {31'd0, prev_wrb}, 32'd0);
      prev_wrb = bus.W_RB;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         regs[i] = 32'h0;
         vals[i] = 32'h9E3779B9 * (i + 1);
      end
      bus.IN_VALID = 0; bus.DEST = 0; bus.W_EN = 0; bus.SRC_SEL = 0;
      bus.ALU_RES = 0; bus.PC = 0; bus.MEM_DATA = 0; bus.MEM_VALID = 0;
      bus.RA = 0; bus.RB = 0;

      tick(); tick();
      check("rst_wc",  {28'd0, bus.WC}, 32'd0);
      check("rst_wpc", bus.WPC, 32'd0);
      check("rst_wrb", {31'd0, bus.W_RB}, 32'd0);
      check("rst_err", {31'd0, bus.ERR}, 32'd0);
      check("rst_rdy", {31'd0, bus.IN_READY}, 32'd1);
      RST = 1'b0;
      tick();

      // ALU write with forwarding
      bus.RA = 4'd5;
      issue(4'd5, 1'b1, 2'b00, 32'hDEADBEEF, 32'h0);
      tick();
      bus.IN_VALID = 0;
      check("alu_wrb",   {31'd0, bus.W_RB}, 32'd1);
      check("alu_wc",    {28'd0, bus.WC}, 32'd5);
      check("alu_wpc",   bus.WPC, 32'hDEADBEEF);
      check("alu_fwda",  {31'd0, bus.FWD_A}, 32'd1);
      check("alu_fwdd",  bus.FWD_DATA, 32'hDEADBEEF);
      check("alu_rdy",   {31'd0, bus.IN_READY}, 32'd0);
      tick();
      check("alu_wrb0",  {31'd0, bus.W_RB}, 32'd0);
      check("alu_fwda0", {31'd0, bus.FWD_A}, 32'd0);
      check("alu_fwdd0", bus.FWD_DATA, 32'd0);
      check("alu_hold",  {28'd0, bus.WC}, 32'd5);
      check("alu_pra",   regs[bus.RA], 32'hDEADBEEF);

      // Load, data on third WAIT_MEM cycle
      bus.RA = 4'd0; bus.RB = 4'd7;
      issue(4'd7, 1'b1, 2'b01, 32'h0, 32'h0);
      tick();
      bus.IN_VALID = 0;
      for (int i = 0; i < 3; i++) begin
         check("ld_haz", {31'd0, bus.HAZ}, 32'd1);
         check("ld_rdy", {31'd0, bus.IN_READY}, 32'd0);
         if (i == 2) begin bus.MEM_VALID = 1; bus.MEM_DATA = 32'h12345678; end
         tick();
      end
      bus.MEM_VALID = 0;
      check("ld_wrb",  {31'd0, bus.W_RB}, 32'd1);
      check("ld_wc",   {28'd0, bus.WC}, 32'd7);
      check("ld_wpc",  bus.WPC, 32'h12345678);
      check("ld_haz0", {31'd0, bus.HAZ}, 32'd0);
      check("ld_fwdb", {31'd0, bus.FWD_B}, 32'd1);
      tick();
      check("ld_prb",  regs[bus.RB], 32'h12345678);

      // Load timeout: 15 WAIT_MEM cycles then ERR
      bus.RB = 4'd0;
      issue(4'd3, 1'b1, 2'b01, 32'h0, 32'h0);
      tick();
      bus.IN_VALID = 0;
      for (int i = 0; i < 15; i++) begin
         check("to_rdy", {31'd0, bus.IN_READY}, 32'd0);
         check("to_err", {31'd0, bus.ERR}, 32'd0);
         check("to_wrb", {31'd0, bus.W_RB}, 32'd0);
         tick();
      end
      check("to_err1", {31'd0, bus.ERR}, 32'd1);
      check("to_rdy1", {31'd0, bus.IN_READY}, 32'd1);
      check("to_wrb1", {31'd0, bus.W_RB}, 32'd0);
      tick();
      check("to_err0", {31'd0, bus.ERR}, 32'd0);
      check("to_r3",   regs[3], 32'h0);

      // MEM_VALID on the expiry cycle: data wins
      issue(4'd4, 1'b1, 2'b01, 32'h0, 32'h0);
      tick();
      bus.IN_VALID = 0;
      for (int i = 0; i < 14; i++) tick();
      bus.MEM_VALID = 1; bus.MEM_DATA = 32'hA5A50F0F;
      tick();
      bus.MEM_VALID = 0;
      check("exp_wrb", {31'd0, bus.W_RB}, 32'd1);
      check("exp_wpc", bus.WPC, 32'hA5A50F0F);
      check("exp_err", {31'd0, bus.ERR}, 32'd0);
      tick();
      check("exp_err0", {31'd0, bus.ERR}, 32'd0);

      // Link wrap
      issue(4'd14, 1'b1, 2'b10, 32'h0, 32'hFFFFFFFF);
      tick();
      bus.IN_VALID = 0;
      check("lnk_wrb", {31'd0, bus.W_RB}, 32'd1);
      check("lnk_wc",  {28'd0, bus.WC}, 32'd14);
      check("lnk_wpc", bus.WPC, 32'h00000000);
      tick();

      // Illegal source
      issue(4'd9, 1'b1, 2'b11, 32'h55555555, 32'h0);
      tick();
      bus.IN_VALID = 0;
      check("ill_err", {31'd0, bus.ERR}, 32'd1);
      check("ill_wrb", {31'd0, bus.W_RB}, 32'd0);
      check("ill_rdy", {31'd0, bus.IN_READY}, 32'd1);
      check("ill_wc",  {28'd0, bus.WC}, 32'd14);
      tick();
      check("ill_err0", {31'd0, bus.ERR}, 32'd0);

      // W_EN=0: fields update, no pulse, no forwarding
      bus.RA = 4'd2;
      issue(4'd2, 1'b0, 2'b00, 32'h11112222, 32'h0);
      tick();
      bus.IN_VALID = 0;
      check("nwe_wrb",  {31'd0, bus.W_RB}, 32'd0);
      check("nwe_wc",   {28'd0, bus.WC}, 32'd2);
      check("nwe_wpc",  bus.WPC, 32'h11112222);
      check("nwe_fwda", {31'd0, bus.FWD_A}, 32'd0);
      tick();
      check("nwe_r2", regs[2], 32'h0);

      // Back-to-back fill of all 16 registers
      for (int i = 0; i < 16; i++) begin
         issue(4'(i), 1'b1, 2'b00, vals[i], 32'h0);
         tick();
         check("fill_wrb", {31'd0, bus.W_RB}, 32'd1);
         check("fill_wc",  {28'd0, bus.WC}, i);
         tick();
         check("fill_gap", {31'd0, bus.W_RB}, 32'd0);
      end
      bus.IN_VALID = 0;
      tick();
      for (int i = 0; i < 16; i++) begin
         bus.RA = 4'(i);
         bus.RB = 4'((i + 1) % 16);
         #1;
         check("rd_a", regs[bus.RA], vals[i]);
         check("rd_b", regs[bus.RB], vals[(i + 1) % 16]);
      end

      // Reset mid-WAIT_MEM abandons the load
      bus.RA = 4'd0; bus.RB = 4'd0;
      issue(4'd6, 1'b1, 2'b01, 32'h0, 32'h0);
      tick();
      bus.IN_VALID = 0;
      tick();
      RST = 1'b1;
      #1;
      check("mr_wrb", {31'd0, bus.W_RB}, 32'd0);
      check("mr_wc",  {28'd0, bus.WC}, 32'd0);
      check("mr_wpc", bus.WPC, 32'd0);
      check("mr_err", {31'd0, bus.ERR}, 32'd0);
      check("mr_rdy", {31'd0, bus.IN_READY}, 32'd1);
      bus.MEM_VALID = 1; bus.MEM_DATA = 32'h0BADF00D;
      tick();
      RST = 1'b0;
      tick();
      check("mr_nowr", {31'd0, bus.W_RB}, 32'd0);
      bus.MEM_VALID = 0;
      issue(4'd1, 1'b1, 2'b00, 32'hCAFEF00D, 32'h0);
      tick();
      bus.IN_VALID = 0;
      check("mr_next_wrb", {31'd0, bus.W_RB}, 32'd1);
      check("mr_next_wpc", bus.WPC, 32'hCAFEF00D);
      tick();
      check("mr_r6", regs[6], vals[6]);
      check("mr_r1", regs[1], 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage, directly upstream of register_bank. Drives register_bank's WC, WPC and W_RB.
- Accepts one retiring instruction at a time via a valid/ready handshake. Selects its result from ALU, memory load data or link address, then commits it as a single one-cycle write pulse.
- Also reports forwarding and hazard information for the operand-read ports RA/RB.

Parameters:
- DATA_W, 32, data width of results and of WPC.
- ADDR_W, 4, register index width (16 registers).
- MEM_TIMEOUT, 15, maximum cycles spent in WAIT_MEM before abort.
- LINK_OFFSET, 1, value added to PC for a link write.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  retiring instruction present.
- IN_READY  out  1  unit can accept an instruction this cycle.
- DEST  in  ADDR_W  destination register index.
- W_EN  in  1  instruction writes a register.
- SRC_SEL  in  2  result source: 00 ALU, 01 MEM, 10 LINK, 11 illegal.
- ALU_RES  in  DATA_W  ALU result.
- PC  in  DATA_W  instruction PC.
- MEM_DATA  in  DATA_W  load data.
- MEM_VALID  in  1  MEM_DATA valid this cycle.
- RA  in  ADDR_W  operand A index, shared with register_bank.
- RB  in  ADDR_W  operand B index, shared with register_bank.
- WC  out  ADDR_W  write index to register_bank.
- WPC  out  DATA_W  write data to register_bank.
- W_RB  out  1  write enable to register_bank.
- FWD_A  out  1  PRA must be replaced by FWD_DATA.
- FWD_B  out  1  PRB must be replaced by FWD_DATA.
- FWD_DATA  out  DATA_W  pending commit value.
- HAZ  out  1  operand depends on an outstanding load; upstream must stall.
- ERR  out  1  one-cycle pulse on illegal SRC_SEL or memory timeout.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, WC=0, WPC=0, W_RB=0, ERR=0, timeout counter=0, captured fields=0. Reset during WAIT_MEM abandons the load; no write occurs.
- States and outputs:
  - IDLE: IN_READY=1.
  - WAIT_MEM and COMMIT: IN_READY=0.
- IDLE, transfer on IN_VALID&IN_READY at a rising edge:
  - Capture DEST and W_EN.
  - SRC_SEL=00: value=ALU_RES, next state COMMIT.
  - SRC_SEL=10: value=PC+LINK_OFFSET, truncated to DATA_W (wraps at 2^DATA_W), next state COMMIT.
  - SRC_SEL=01: counter=0, next state WAIT_MEM.
  - SRC_SEL=11: ERR=1 next cycle, stay IDLE, no write.
- WAIT_MEM:
  - MEM_VALID=1: value=MEM_DATA, next state COMMIT.
  - Otherwise counter increments. When counter==MEM_TIMEOUT-1 without MEM_VALID: ERR pulse, next state IDLE, no write.
  - MEM_VALID on the expiry cycle: data wins, go to COMMIT.
- COMMIT (exactly one cycle), registered outputs:
  - W_RB=W_EN_q.
  - WC=DEST_q, WPC=value, both loaded on the edge entering COMMIT.
  - Next state always IDLE; W_RB returns to 0.
- Write timing rules:
  - WC/WPC are stable for the whole cycle W_RB=1 and hold their values after; they change only on an edge entering COMMIT.
  - W_RB is never high on two consecutive cycles.
  - Throughput: ALU/LINK instructions retire one per 2 cycles; a load takes ≥3 cycles.
- MEM_VALID is ignored outside WAIT_MEM.
- W_EN_q=0 in COMMIT: no write pulse; WC/WPC still update.
- All 16 register indices, including 0, are writable.
- Forwarding (combinational):
  - FWD_A = (state==COMMIT) & W_EN_q & (RA==DEST_q).
  - FWD_B = (state==COMMIT) & W_EN_q & (RB==DEST_q).
  - FWD_DATA = committed value in COMMIT, else 0.
- HAZ (combinational) = (state==WAIT_MEM) & W_EN_q & (RA==DEST_q | RB==DEST_q).
- ERR is registered and high for exactly one cycle per event.

Test Plan:
- Reset, then ALU write: DEST=5, SRC_SEL=00, ALU_RES=0xDEADBEEF, W_EN=1 -> next cycle W_RB=1, WC=5, WPC=0xDEADBEEF for one cycle; register_bank then reads PRA=0xDEADBEEF with RA=5. While W_RB=1, RA=5 gives FWD_A=1 and FWD_DATA=0xDEADBEEF.
- Load with MEM_VALID 3 cycles after accept, MEM_DATA=0x12345678, DEST=7, RB=7 -> HAZ=1 throughout WAIT_MEM, IN_READY=0, then one W_RB pulse with WC=7, WPC=0x12345678.
- Load with no MEM_VALID -> ERR pulse after exactly 15 WAIT_MEM cycles, W_RB never asserted, IN_READY=1 on return to IDLE. Repeat with MEM_VALID on cycle 15 -> write occurs, no ERR.
- Link: PC=0xFFFFFFFF, SRC_SEL=10, DEST=14 -> WPC=0x00000000 (wrap), WC=14. SRC_SEL=11 -> ERR pulse, no write. W_EN=0 -> no W_RB pulse.
- Fill all 16 registers back-to-back with random values, holding IN_VALID high -> W_RB pulses every other cycle, never two consecutive cycles. Readback through register_bank RA=i/RB=i+1 matches all values.
- Assert RST mid-WAIT_MEM, then MEM_VALID -> all outputs 0 immediately, no write, next instruction accepted normally.
